oled_frame_tx: RTL and testbench

- Frame transmitter on the far side of the pixel interface that the OLED content generators consume.
- Drives `pixel_index`, samples the returned `oled_data`, and streams each complete 96x64 RGB565 frame to the SSD1331 over its 4-wire serial bus.
- Each frame is preceded by a column/row address-window command sequence.
- Sits between the display-content muxes and the Pmod OLED pins.

---
 rtl/oled_pkg.sv | 30 +++
 rtl/oled_spi_shifter.sv | 63 ++++++
 rtl/oled_frame_tx.sv | 139 +++++++++++++
 tb/tb_oled_frame_tx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared constants, state encoding and command table for the OLED frame transmitter
package oled_pkg;

    localparam int DEF_WIDTH  = 96;
    localparam int DEF_HEIGHT = 64;
    localparam int NPIX       = DEF_WIDTH * DEF_HEIGHT;
    localparam int PIX_W      = 13;

    localparam logic [7:0] CMD_SETCOL = 8'h15;
    localparam logic [7:0] CMD_SETROW = 8'h75;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        PIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Address-window sequence: column range 0..w-1, then row range 0..h-1.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input int w, input int h);
        case (idx)
            3'd0:    return CMD_SETCOL;
            3'd2:    return 8'(w - 1);
            3'd3:    return CMD_SETROW;
            3'd5:    return 8'(h - 1);
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/oled_spi_shifter.sv
// rtl/oled_spi_shifter.sv - 8/16-bit MSB-first serial shifter with sclk divider and word_done strobe
module oled_spi_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        len16,
    input  logic [15:0] load_data,
    output logic        sclk,
    output logic        sdin,
    output logic        word_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [15:0]      sr;
    logic [DIV_W-1:0] div;
    logic [3:0]       bit_cnt;
    logic             active;
    logic             len16_q;

    assign sdin = sr[15];

    // High in the final cycle of the final bit, so a follow-on load lands with no gap.
    assign word_done = active && sclk && (div == DIV_LAST) &&
                       (bit_cnt == (len16_q ? 4'd15 : 4'd7));

    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= 16'h0000;
            div     <= '0;
            bit_cnt <= 4'd0;
            active  <= 1'b0;
            len16_q <= 1'b0;
            sclk    <= 1'b1;
        end else if (load) begin
            sr      <= len16 ? load_data : {load_data[7:0], 8'h00};
            div     <= '0;
            bit_cnt <= 4'd0;
            active  <= 1'b1;
            len16_q <= len16;
            sclk    <= 1'b0;
        end else if (active) begin
            if (div != DIV_LAST) begin
                div <= div + 1'b1;
            end else begin
                div <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else if (word_done) begin
                    active <= 1'b0;
                end else begin
                    sclk    <= 1'b0;
                    sr      <= {sr[14:0], 1'b0};
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/oled_frame_tx.sv
// rtl/oled_frame_tx.sv - sequences the address-window commands and one full RGB565 frame to the SSD1331
module oled_frame_tx
    import oled_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int HEIGHT  = DEF_HEIGHT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_frame,
    input  logic [15:0] oled_data,
    output logic [12:0] pixel_index,
    output logic        cs,
    output logic        sclk,
    output logic        sdin,
    output logic        d_cn,
    output logic        busy,
    output logic        frame_done
);

    localparam int NPIX_L = WIDTH * HEIGHT;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NPIX_L - 1);

    state_t           state;
    logic             starting;
    logic [2:0]       cmd_idx;
    logic [PIX_W-1:0] pix_cnt;

    logic        load;
    logic        len16;
    logic [15:0] load_data;
    logic        word_done;

    oled_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .len16     (len16),
        .load_data (load_data),
        .sclk      (sclk),
        .sdin      (sdin),
        .word_done (word_done)
    );

    // Next word is chosen in the last cycle of the current one so bits run back to back.
    always_comb begin
        load      = 1'b0;
        len16     = 1'b0;
        load_data = 16'h0000;
        case (state)
            CMD: begin
                if (starting) begin
                    load      = 1'b1;
                    load_data = {8'h00, cmd_byte(3'd0, WIDTH, HEIGHT)};
                end else if (word_done) begin
                    load = 1'b1;
                    if (cmd_idx == 3'd5) begin
                        len16     = 1'b1;
                        load_data = oled_data;
                    end else begin
                        load_data = {8'h00, cmd_byte(cmd_idx + 3'd1, WIDTH, HEIGHT)};
                    end
                end
            end
            PIX: begin
                if (word_done && (pix_cnt != LAST_PIX)) begin
                    load      = 1'b1;
                    len16     = 1'b1;
                    load_data = oled_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            starting    <= 1'b0;
            cmd_idx     <= 3'd0;
            pix_cnt     <= '0;
            pixel_index <= '0;
            cs          <= 1'b1;
            d_cn        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (start_frame) begin
                        state    <= CMD;
                        busy     <= 1'b1;
                        starting <= 1'b1;
                        cmd_idx  <= 3'd0;
                    end
                end
                CMD: begin
                    if (starting) begin
                        starting <= 1'b0;
                        cs       <= 1'b0;
                        d_cn     <= 1'b0;
                    end else if (word_done) begin
                        if (cmd_idx == 3'd5) begin
                            state       <= PIX;
                            d_cn        <= 1'b1;
                            pix_cnt     <= '0;
                            pixel_index <= (LAST_PIX == '0) ? '0 : pixel_index + 1'b1;
                        end else begin
                            cmd_idx <= cmd_idx + 3'd1;
                        end
                    end
                end
                PIX: begin
                    if (word_done) begin
                        if (pix_cnt == LAST_PIX) begin
                            state       <= DONE;
                            cs          <= 1'b1;
                            d_cn        <= 1'b0;
                            busy        <= 1'b0;
                            frame_done  <= 1'b1;
                            pixel_index <= '0;
                        end else begin
                            pix_cnt     <= pix_cnt + 1'b1;
                            pixel_index <= (pixel_index == LAST_PIX) ? '0 : pixel_index + 1'b1;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_frame_tx.sv
// tb/tb_oled_frame_tx.sv - scoreboard bench for oled_frame_tx at CLK_DIV=2 and CLK_DIV=1
module tb_oled_frame_tx;

    localparam int W    = 16;
    localparam int H    = 8;
    localparam int NP   = W * H;
    localparam int BITS = 48 + 16 * NP;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic [15:0] a_data, b_data;
    logic [12:0] a_idx, b_idx;
    logic a_cs, a_sclk, a_sdin, a_dcn, a_busy, a_fd;
    logic b_cs, b_sclk, b_sdin, b_dcn, b_busy, b_fd;

    always #5 clk = ~clk;

    assign a_data = {3'b000, a_idx};
    assign b_data = 16'hA5C3;

    oled_frame_tx #(.CLK_DIV(2), .WIDTH(W), .HEIGHT(H)) dut_a (
        .clk(clk), .reset(reset), .start_frame(start_a), .oled_data(a_data),
        .pixel_index(a_idx), .cs(a_cs), .sclk(a_sclk), .sdin(a_sdin),
        .d_cn(a_dcn), .busy(a_busy), .frame_done(a_fd)
    );

    oled_frame_tx #(.CLK_DIV(1), .WIDTH(W), .HEIGHT(H)) dut_b (
        .clk(clk), .reset(reset), .start_frame(start_b), .oled_data(b_data),
        .pixel_index(b_idx), .cs(b_cs), .sclk(b_sclk), .sdin(b_sdin),
        .d_cn(b_dcn), .busy(b_busy), .frame_done(b_fd)
    );

    bit sel = 1'b0;
    logic m_cs, m_sclk, m_sdin, m_dcn, m_busy, m_fd;
    logic [12:0] m_idx;
    assign m_cs   = sel ? b_cs   : a_cs;
    assign m_sclk = sel ? b_sclk : a_sclk;
    assign m_sdin = sel ? b_sdin : a_sdin;
    assign m_dcn  = sel ? b_dcn  : a_dcn;
    assign m_busy = sel ? b_busy : a_busy;
    assign m_fd   = sel ? b_fd   : a_fd;
    assign m_idx  = sel ? b_idx  : a_idx;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [16:0] exp_q[$];
    logic [15:0] shreg = 16'h0;
    int nbits = 0;
    int rises = 0;
    int low_cyc = 0;
    int sdin_viol = 0;
    logic prev_sclk = 1'b1;
    logic prev_sdin = 1'b0;

    // Bus monitor: decode words on rising sclk while cs is low.
    always @(negedge clk) begin
        logic [16:0] obs;
        logic [16:0] e;
        if (m_sclk && prev_sclk && (m_sdin !== prev_sdin)) sdin_viol++;
        if (!m_cs) low_cyc++;
        if (m_cs) begin
            nbits = 0;
        end else if (m_sclk && !prev_sclk) begin
            rises++;
            shreg = {shreg[14:0], m_sdin};
            nbits++;
            if (nbits == (m_dcn ? 16 : 8)) begin
                obs = m_dcn ? {1'b1, shreg} : {1'b0, 8'h00, shreg[7:0]};
                if (exp_q.size() == 0) begin
                    check_eq("sb_extra_word", 32'(obs), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq(m_dcn ? "pix_word" : "cmd_byte", 32'(obs), 32'(e));
                end
                nbits = 0;
            end
        end
        prev_sclk = m_sclk;
        prev_sdin = m_sdin;
    end

    task automatic drive_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic push_frame();
        logic [7:0] cmds [6];
        cmds = '{8'h15, 8'h00, 8'(W - 1), 8'h75, 8'h00, 8'(H - 1)};
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'h00, cmds[i]});
        for (int i = 0; i < NP; i++)
            exp_q.push_back(sel ? {1'b1, 16'hA5C3} : {1'b1, 3'b000, 13'(i)});
    endtask

    // Returns with the first negedge after edge k already consumed.
    task automatic kick();
        push_frame();
        @(posedge clk);
        #1;
        drive_start(1'b1);
        @(posedge clk);
        #1;
        drive_start(1'b0);
        rises = 0;
        low_cyc = 0;
        sdin_viol = 0;
        @(negedge clk);
    endtask

    task automatic run_frame(input bit pokes);
        int div;
        int lat;
        int n;
        int done_n;
        int extra_fd;
        int extra_low;
        div = sel ? 1 : 2;
        lat = 1 + BITS * 2 * div;
        kick();
        check_eq("cs_at_k", 32'(m_cs), 32'd1);
        @(negedge clk);
        check_eq("cs_fall_k1", 32'(m_cs), 32'd0);
        check_eq("dcn_cmd", 32'(m_dcn), 32'd0);
        check_eq("busy_k1", 32'(m_busy), 32'd1);
        n = 1;
        done_n = -1;
        while (n <= lat + 50) begin
            @(negedge clk);
            n++;
            if (pokes && n == lat / 2) drive_start(1'b1);
            else if (pokes && n == lat / 2 + 1) drive_start(1'b0);
            if (m_fd) begin
                done_n = n;
                break;
            end
        end
        check_eq("frame_done_latency", 32'(done_n), 32'(lat));
        check_eq("done_cs", 32'(m_cs), 32'd1);
        check_eq("done_sclk", 32'(m_sclk), 32'd1);
        check_eq("done_busy", 32'(m_busy), 32'd0);
        check_eq("done_pidx", 32'(m_idx), 32'd0);
        if (pokes) drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        check_eq("idle_fd", 32'(m_fd), 32'd0);
        check_eq("idle_cs", 32'(m_cs), 32'd1);
        check_eq("idle_busy", 32'(m_busy), 32'd0);
        extra_fd = 0;
        extra_low = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_fd) extra_fd++;
            if (!m_cs) extra_low++;
        end
        check_eq("no_extra_done", 32'(extra_fd), 32'd0);
        check_eq("no_restart", 32'(extra_low), 32'd0);
        check_eq("sb_left", 32'(exp_q.size()), 32'd0);
        check_eq("bit_count", 32'(rises), 32'(BITS));
        check_eq("cs_low_cycles", 32'(low_cyc), 32'(BITS * 2 * div));
        check_eq("sdin_stable", 32'(sdin_viol), 32'd0);
    endtask

    initial begin
        int n;
        sel = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cs", 32'(a_cs), 32'd1);
        check_eq("rst_sclk", 32'(a_sclk), 32'd1);
        check_eq("rst_sdin", 32'(a_sdin), 32'd0);
        check_eq("rst_dcn", 32'(a_dcn), 32'd0);
        check_eq("rst_pidx", 32'(a_idx), 32'd0);
        check_eq("rst_busy", 32'(a_busy), 32'd0);
        check_eq("rst_fd", 32'(a_fd), 32'd0);
        check_eq("rst_b_cs", 32'(b_cs), 32'd1);
        reset = 1'b0;

        run_frame(1'b1);

        kick();
        n = 0;
        while (a_idx != 13'd101 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_pixel_100", 32'(a_idx), 32'd101);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_cs", 32'(a_cs), 32'd1);
        check_eq("midrst_sclk", 32'(a_sclk), 32'd1);
        check_eq("midrst_busy", 32'(a_busy), 32'd0);
        check_eq("midrst_pidx", 32'(a_idx), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();

        run_frame(1'b0);

        sel = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
